cnt_share_ctrl: RTL



---
 rtl/cnt_share_ctrl.sv | 123 ++++++++++++
 1 files changed

// File: rtl/cnt_share_ctrl.sv
// cnt_share_ctrl
//   Shares one external W-bit up-counter (parallel load, carry C = &A)
//   between two requesters as a one-shot interval timer. Requesters are
//   arbitrated round-robin. The counter is loaded with ~L so that C rises
//   after exactly L count cycles, and the owner then gets a one-cycle done
//   pulse.
//
// Ports
//   clk_i     clock, rising edge
//   rst_i     asynchronous reset, active low
//   req_i2    per-requester request, held until that requester's done
//   len0_i4   count length for requester 0, sampled at grant
//   len1_i4   count length for requester 1, sampled at grant
//   gnt_o2    one-hot owner, high from grant through DONE
//   done_o2   one-cycle completion pulse to the owner
//   busy_o    high whenever the controller is not idle
//   ld_o      counter parallel-load enable
//   cnt_o     counter count enable
//   I_o4      counter load value (zero outside LOAD)
//   A_i4      counter value, monitor only
//   C_i       counter carry, high when the counter is all ones
//
// Optional feature macro: CNT_SHARE_ABORT_EN
//   When defined, an owner that drops its request during LOAD or COUNT
//   abandons the job. The controller returns to IDLE without a done pulse.
//   When undefined, the job always runs to DONE.
module cnt_share_ctrl #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [1:0]   req_i2,
  input  logic [W-1:0] len0_i4,
  input  logic [W-1:0] len1_i4,
  output logic [1:0]   gnt_o2,
  output logic [1:0]   done_o2,
  output logic         busy_o,
  output logic         ld_o,
  output logic         cnt_o,
  output logic [W-1:0] I_o4,
  input  logic [W-1:0] A_i4,
  input  logic         C_i
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COUNT, S_DONE} state_t;

  state_t       r_state, w_state_nxt;
  logic [1:0]   r_gnt,   w_gnt_nxt;
  logic [W-1:0] r_len,   w_len_nxt;
  logic         r_ptr,   w_ptr_nxt;
  logic         w_win;
  logic         w_own_req;
  logic         w_unused;

  // The counter value is only observed and is not needed for control.
  assign w_unused = ^A_i4;

  // If both requesters are pending, ptr picks the winner. Otherwise the
  // single active requester wins.
  assign w_win     = (req_i2 == 2'b11) ? r_ptr : req_i2[1];
  assign w_own_req = |(req_i2 & r_gnt);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_len   <= '0;
      r_ptr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_len   <= w_len_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_len_nxt   = r_len;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      S_IDLE: begin
        if (|req_i2) begin
          w_state_nxt = S_LOAD;
          w_gnt_nxt   = w_win ? 2'b10 : 2'b01;
          w_len_nxt   = w_win ? len1_i4 : len0_i4;
        end
      end
      S_LOAD:  w_state_nxt = S_COUNT;
      S_COUNT: if (C_i) w_state_nxt = S_DONE;
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_gnt_nxt   = '0;
        // Favour the requester that did not just finish.
        w_ptr_nxt   = r_gnt[0];
      end
      default: w_state_nxt = S_IDLE;
    endcase
`ifdef CNT_SHARE_ABORT_EN
    // An abort takes priority over a carry arriving in the same cycle.
    if ((r_state == S_LOAD || r_state == S_COUNT) && !w_own_req) begin
      w_state_nxt = S_IDLE;
      w_gnt_nxt   = '0;
      w_ptr_nxt   = r_gnt[0];
    end
`else
    if (w_own_req) begin
      // After grant, the owner's request is deliberately ignored.
    end
`endif
  end

  assign gnt_o2  = r_gnt;
  assign done_o2 = (r_state == S_DONE) ? r_gnt : 2'b00;
  assign busy_o  = (r_state != S_IDLE);
  assign ld_o    = (r_state == S_LOAD);
  // Stop counting once the carry is up. With L = 0, the counter is
  // loaded with all ones, so the enable never asserts.
  assign cnt_o   = (r_state == S_COUNT) && !C_i;
  assign I_o4    = (r_state == S_LOAD) ? ~r_len : '0;

endmodule
